// File: rtl/cheshire_idma_job_sched.sv
// Job scheduler sharing one iDMA backend between several job frontends.
//
// Frontends present jobs on a valid/ready stream each. A round-robin arbiter with a
// grant lock selects one stream and forwards its job to the backend with no added
// latency. Every accepted job records its owning stream in an order FIFO. The backend
// answers in order, so each response retires the FIFO head and updates that stream's
// counters.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   stream_req_i           per-stream job request payload
//   stream_valid_i         per-stream request valid
//   stream_ready_o         per-stream request ready (only the granted stream)
//   stream_next_id_o       ID that the next accepted job of the stream receives
//   stream_done_id_o       ID of the last retired job of the stream
//   stream_busy_o          stream has at least one job in flight
//   be_req_o/be_valid_o    request to the backend, be_ready_i its ready
//   be_rsp_i/be_rsp_valid_i backend response (ordering only), be_rsp_ready_o its ready
//   busy_o                 any job in flight or any request pending
module cheshire_idma_job_sched #(
  parameter int unsigned NumStreams     = 2,
  parameter int unsigned MaxInFlight    = 4,
  parameter int unsigned IdCounterWidth = 32,
  parameter type         idma_req_t     = logic,
  parameter type         idma_rsp_t     = logic
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  idma_req_t                                     stream_req_i [NumStreams],
  input  logic      [NumStreams-1:0]                    stream_valid_i,
  output logic      [NumStreams-1:0]                    stream_ready_o,
  output logic      [NumStreams-1:0][IdCounterWidth-1:0] stream_next_id_o,
  output logic      [NumStreams-1:0][IdCounterWidth-1:0] stream_done_id_o,
  output logic      [NumStreams-1:0]                    stream_busy_o,
  output idma_req_t                                     be_req_o,
  output logic                                          be_valid_o,
  input  logic                                          be_ready_i,
  input  idma_rsp_t                                     be_rsp_i,
  input  logic                                          be_rsp_valid_i,
  output logic                                          be_rsp_ready_o,
  output logic                                          busy_o
);

  localparam int unsigned IdxW = (NumStreams > 1) ? $clog2(NumStreams) : 1;
  localparam int unsigned PtrW = (MaxInFlight > 1) ? $clog2(MaxInFlight) : 1;
  localparam int unsigned CntW = $clog2(MaxInFlight + 1);

  // Arbiter state
  logic [IdxW-1:0] rr_q, rr_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;

  // Order FIFO holding the owning stream of each in-flight job
  logic [IdxW-1:0] fifo_q [MaxInFlight];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Per-stream counters
  logic [NumStreams-1:0][IdCounterWidth-1:0] next_id_q, next_id_d;
  logic [NumStreams-1:0][IdCounterWidth-1:0] done_id_q, done_id_d;
  logic [NumStreams-1:0][CntW-1:0]           inflight_q, inflight_d;

  logic            cand_valid;
  logic [IdxW-1:0] cand_idx;
  logic            fifo_full, fifo_empty;
  logic            accept, retire;
  logic [IdxW-1:0] head;

  // Response payload carries no information the scheduler needs.
  logic unused_rsp;
  assign unused_rsp = ^be_rsp_i;

  assign fifo_full  = (count_q == CntW'(MaxInFlight));
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_q[rptr_q];

  // Candidate selection: a held grant wins; otherwise search upward from rr_q with wrap.
  always_comb begin
    int unsigned j;
    cand_valid = 1'b0;
    cand_idx   = '0;
    j          = 0;
    if (lock_q) begin
      cand_valid = stream_valid_i[lock_idx_q];
      cand_idx   = lock_idx_q;
    end else begin
      for (int unsigned k = 0; k < NumStreams; k++) begin
        j = 32'(rr_q) + k;
        if (j >= NumStreams) begin
          j = j - NumStreams;
        end
        if (!cand_valid && stream_valid_i[IdxW'(j)]) begin
          cand_valid = 1'b1;
          cand_idx   = IdxW'(j);
        end
      end
    end
  end

  // A full FIFO blocks issue even when a retire happens in the same cycle.
  assign be_valid_o     = cand_valid & ~fifo_full;
  assign be_req_o       = stream_req_i[cand_idx];
  assign accept         = be_valid_o & be_ready_i;
  assign be_rsp_ready_o = ~fifo_empty;
  assign retire         = be_rsp_valid_i & ~fifo_empty;
  assign busy_o         = ~fifo_empty | (|stream_valid_i);

  always_comb begin
    stream_ready_o = '0;
    if (cand_valid) begin
      stream_ready_o[cand_idx] = be_ready_i & ~fifo_full;
    end
  end

  // Lock and round-robin pointer next state.
  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    rr_d       = rr_q;
    if (accept) begin
      lock_d = 1'b0;
      rr_d   = (cand_idx == IdxW'(NumStreams - 1)) ? '0 : cand_idx + IdxW'(1);
    end else if (be_valid_o) begin
      // Offered but not taken: pin the grant so later arrivals cannot preempt it.
      lock_d     = 1'b1;
      lock_idx_d = cand_idx;
    end
  end

  // Order FIFO pointers and occupancy.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (accept) begin
      wptr_d = (wptr_q == PtrW'(MaxInFlight - 1)) ? '0 : wptr_q + PtrW'(1);
    end
    if (retire) begin
      rptr_d = (rptr_q == PtrW'(MaxInFlight - 1)) ? '0 : rptr_q + PtrW'(1);
    end
    unique case ({accept, retire})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Per-stream ID counters and in-flight counts; accept and retire may hit the same stream.
  always_comb begin
    logic acc_s, ret_s;
    next_id_d  = next_id_q;
    done_id_d  = done_id_q;
    inflight_d = inflight_q;
    acc_s      = 1'b0;
    ret_s      = 1'b0;
    for (int unsigned i = 0; i < NumStreams; i++) begin
      acc_s = accept && (cand_idx == IdxW'(i));
      ret_s = retire && (head == IdxW'(i));
      if (acc_s) begin
        next_id_d[i] = next_id_q[i] + IdCounterWidth'(1);
      end
      if (ret_s) begin
        done_id_d[i] = done_id_q[i] + IdCounterWidth'(1);
      end
      unique case ({acc_s, ret_s})
        2'b10:   inflight_d[i] = inflight_q[i] + CntW'(1);
        2'b01:   inflight_d[i] = inflight_q[i] - CntW'(1);
        default: inflight_d[i] = inflight_q[i];
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < NumStreams; i++) begin
        next_id_q[i]  <= IdCounterWidth'(1);
        done_id_q[i]  <= '0;
        inflight_q[i] <= '0;
      end
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      next_id_q  <= next_id_d;
      done_id_q  <= done_id_d;
      inflight_q <= inflight_d;
    end
  end

  // FIFO storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      fifo_q[wptr_q] <= cand_idx;
    end
  end

  assign stream_next_id_o = next_id_q;
  assign stream_done_id_o = done_id_q;

  always_comb begin
    stream_busy_o = '0;
    for (int unsigned i = 0; i < NumStreams; i++) begin
      stream_busy_o[i] = |inflight_q[i];
    end
  end

`ifndef SYNTHESIS
  // A response with nothing in flight has no owner and is a backend protocol error.
  rsp_while_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     be_rsp_valid_i |-> !fifo_empty);
`endif

endmodule

// File: tb/tb_cheshire_idma_job_sched.sv
// Directed bench for cheshire_idma_job_sched with a scoreboard of job owners.
module tb_cheshire_idma_job_sched;

  localparam int unsigned NS  = 2;
  localparam int unsigned MIF = 4;
  localparam int unsigned IDW = 32;
  typedef logic [7:0] req_t;
  localparam req_t Req0 = 8'h5A;
  localparam req_t Req1 = 8'hC3;

  logic                      clk_i = 1'b0;
  logic                      rst_ni = 1'b0;
  req_t                      stream_req_i [NS];
  logic [NS-1:0]             stream_valid_i = '0;
  logic [NS-1:0]             stream_ready_o;
  logic [NS-1:0][IDW-1:0]    stream_next_id_o;
  logic [NS-1:0][IDW-1:0]    stream_done_id_o;
  logic [NS-1:0]             stream_busy_o;
  req_t                      be_req_o;
  logic                      be_valid_o;
  logic                      be_ready_i = 1'b0;
  logic                      be_rsp_i = 1'b0;
  logic                      be_rsp_valid_i = 1'b0;
  logic                      be_rsp_ready_o;
  logic                      busy_o;

  always #5 clk_i = ~clk_i;

  cheshire_idma_job_sched #(
    .NumStreams    (NS),
    .MaxInFlight   (MIF),
    .IdCounterWidth(IDW),
    .idma_req_t    (req_t),
    .idma_rsp_t    (logic)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .stream_req_i    (stream_req_i),
    .stream_valid_i  (stream_valid_i),
    .stream_ready_o  (stream_ready_o),
    .stream_next_id_o(stream_next_id_o),
    .stream_done_id_o(stream_done_id_o),
    .stream_busy_o   (stream_busy_o),
    .be_req_o        (be_req_o),
    .be_valid_o      (be_valid_o),
    .be_ready_i      (be_ready_i),
    .be_rsp_i        (be_rsp_i),
    .be_rsp_valid_i  (be_rsp_valid_i),
    .be_rsp_ready_o  (be_rsp_ready_o),
    .busy_o          (busy_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: owners of in-flight jobs in issue order plus expected counters.
  int              owner_q [$];
  logic [IDW-1:0]  exp_next [NS];
  logic [IDW-1:0]  exp_done [NS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner_q.delete();
    for (int s = 0; s < NS; s++) begin
      exp_next[s] = 1;
      exp_done[s] = 0;
    end
  endtask

  task automatic check_state(input string tag);
    int cnt;
    for (int s = 0; s < NS; s++) begin
      cnt = 0;
      foreach (owner_q[k]) if (owner_q[k] == s) cnt++;
      chk($sformatf("%s next_id[%0d]", tag, s), 64'(stream_next_id_o[s]), 64'(exp_next[s]));
      chk($sformatf("%s done_id[%0d]", tag, s), 64'(stream_done_id_o[s]), 64'(exp_done[s]));
      chk($sformatf("%s stream_busy[%0d]", tag, s), 64'(stream_busy_o[s]), 64'(cnt != 0));
    end
  endtask

  task automatic apply_reset();
    rst_ni         = 1'b0;
    stream_valid_i = '0;
    be_ready_i     = 1'b0;
    be_rsp_valid_i = 1'b0;
    model_reset();
    #2;
    rst_ni = 1'b1;
  endtask

  // One clock cycle: drive, check combinational outputs mid-cycle, update model at the
  // edge, then check registered state just after it. g is the stream expected on grant.
  task automatic tick(input string tag, input logic [1:0] v, input logic rdy, input logic rv,
                      input logic exp_bv, input int g);
    logic [NS-1:0] exp_srdy;
    int            h;
    stream_valid_i = v;
    be_ready_i     = rdy;
    be_rsp_valid_i = rv;
    #4;
    exp_srdy = '0;
    if (exp_bv && rdy) exp_srdy[g] = 1'b1;
    chk({tag, " be_valid"}, 64'(be_valid_o), 64'(exp_bv));
    chk({tag, " stream_ready"}, 64'(stream_ready_o), 64'(exp_srdy));
    if (exp_bv) chk({tag, " be_req"}, 64'(be_req_o), 64'((g == 0) ? Req0 : Req1));
    chk({tag, " rsp_ready"}, 64'(be_rsp_ready_o), 64'(owner_q.size() != 0));
    chk({tag, " busy"}, 64'(busy_o), 64'((owner_q.size() != 0) || (v != 0)));
    @(posedge clk_i);
    if (rv && owner_q.size() != 0) begin
      h = owner_q.pop_front();
      exp_done[h] = exp_done[h] + 1;
    end
    if (exp_bv && rdy) begin
      owner_q.push_back(g);
      exp_next[g] = exp_next[g] + 1;
    end
    #1;
    check_state(tag);
  endtask

  initial begin
    stream_req_i[0] = Req0;
    stream_req_i[1] = Req1;
    model_reset();
    #12;
    rst_ni = 1'b1;
    #1;
    chk("reset stream_ready", 64'(stream_ready_o), 64'(0));
    chk("reset be_valid", 64'(be_valid_o), 64'(0));
    chk("reset rsp_ready", 64'(be_rsp_ready_o), 64'(0));
    chk("reset busy", 64'(busy_o), 64'(0));
    check_state("reset");
    @(posedge clk_i);
    #1;

    // Single job on stream 0, then its response.
    tick("single issue", 2'b01, 1'b1, 1'b0, 1'b1, 0);
    tick("single rsp", 2'b00, 1'b1, 1'b1, 1'b0, 0);

    // Round-robin alternation from a fresh reset fills the FIFO.
    apply_reset();
    tick("rr 0", 2'b11, 1'b1, 1'b0, 1'b1, 0);
    tick("rr 1", 2'b11, 1'b1, 1'b0, 1'b1, 1);
    tick("rr 2", 2'b11, 1'b1, 1'b0, 1'b1, 0);
    tick("rr 3", 2'b11, 1'b1, 1'b0, 1'b1, 1);
    // Full: nothing issues, even with a response in the same cycle.
    tick("full blocked", 2'b11, 1'b1, 1'b0, 1'b0, 0);
    tick("full rsp no fallthru", 2'b01, 1'b1, 1'b1, 1'b0, 0);
    tick("full resume", 2'b01, 1'b1, 1'b0, 1'b1, 0);
    for (int i = 0; i < 4; i++) tick($sformatf("drain %0d", i), 2'b00, 1'b1, 1'b1, 1'b0, 0);

    // Grant lock: stream 1 waits on backend, stream 0 arrives later and must not preempt.
    apply_reset();
    tick("lock wait 0", 2'b10, 1'b0, 1'b0, 1'b1, 1);
    for (int i = 1; i < 5; i++) tick($sformatf("lock wait %0d", i), 2'b11, 1'b0, 1'b0, 1'b1, 1);
    tick("lock handshake", 2'b11, 1'b1, 1'b0, 1'b1, 1);
    tick("lock then s0", 2'b01, 1'b1, 1'b0, 1'b1, 0);
    tick("lock rsp a", 2'b00, 1'b1, 1'b1, 1'b0, 0);
    tick("lock rsp b", 2'b00, 1'b1, 1'b1, 1'b0, 0);

    // Interleaved owners 0,1,1,0 retired in order.
    apply_reset();
    tick("il issue 0", 2'b01, 1'b1, 1'b0, 1'b1, 0);
    tick("il issue 1", 2'b10, 1'b1, 1'b0, 1'b1, 1);
    tick("il issue 2", 2'b10, 1'b1, 1'b0, 1'b1, 1);
    tick("il issue 3", 2'b01, 1'b1, 1'b0, 1'b1, 0);
    for (int i = 0; i < 4; i++) tick($sformatf("il rsp %0d", i), 2'b00, 1'b1, 1'b1, 1'b0, 0);
    tick("il idle", 2'b00, 1'b1, 1'b0, 1'b0, 0);

    // Accept and retire on stream 0 in the same cycle.
    tick("same issue", 2'b01, 1'b1, 1'b0, 1'b1, 0);
    tick("same acc+ret", 2'b01, 1'b1, 1'b1, 1'b1, 0);
    tick("same drain", 2'b00, 1'b1, 1'b1, 1'b0, 0);
    tick("final idle", 2'b00, 1'b0, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
